// File: rtl/axi_arbitrate_rd.sv
// Round-robin AXI4 read arbiter: four frame-buffer channels share one AXI read port,
// one fixed-length INCR burst per grant, R beats steered to the granted channel.
module axi_arbitrate_rd #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned DQ_WIDTH        = 32,
  parameter int unsigned BURST_LEN       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     ch_req,
  input  logic [4*CTRL_ADDR_WIDTH-1:0]   ch_addr,
  input  logic [3:0]                     ch_ready,
  output logic [3:0]                     ch_grant,
  output logic [3:0]                     ch_rvalid,
  output logic [DQ_WIDTH*8-1:0]          ch_rdata,
  output logic [3:0]                     ch_done,
  output logic                           err,
  output logic [CTRL_ADDR_WIDTH-1:0]     axi_araddr,
  output logic [3:0]                     axi_arid,
  output logic [3:0]                     axi_arlen,
  output logic [2:0]                     axi_arsize,
  output logic [1:0]                     axi_arburst,
  output logic                           axi_arvalid,
  input  logic                           axi_arready,
  input  logic [DQ_WIDTH*8-1:0]          axi_rdata,
  input  logic [3:0]                     axi_rid,
  input  logic                           axi_rlast,
  input  logic                           axi_rvalid,
  output logic                           axi_rready
);

  localparam int unsigned DW = DQ_WIDTH * 8;
  localparam int unsigned CW = $clog2(BURST_LEN + 1);
  localparam logic [CW:0] BL_CNT = (CW+1)'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  ptr, ptr_nxt;
  logic [1:0]                  sel, sel_nxt;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic [CW:0]                 cnt_inc;
  logic [3:0]                  grant_nxt, rvalid_nxt, done_nxt;
  logic [DW-1:0]               rdata_nxt;
  logic                        err_nxt, arvalid_nxt;
  logic [CTRL_ADDR_WIDTH-1:0]  araddr_nxt;
  logic [3:0]                  arid_nxt;
  logic                        pick_vld;
  logic [1:0]                  pick;
  logic                        beat;

  assign axi_arlen   = 4'(BURST_LEN - 1);
  assign axi_arsize  = 3'($clog2(DQ_WIDTH));
  assign axi_arburst = 2'b01;

  assign axi_rready = (state == S_DATA) && ch_ready[sel];
  assign beat       = axi_rvalid && axi_rready;
  assign cnt_inc    = {1'b0, cnt} + (CW+1)'(1);

  // First requester at or after ptr; descending scan so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (ch_req[2'(ptr + 2'(i))]) begin
        pick_vld = 1'b1;
        pick     = 2'(ptr + 2'(i));
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    grant_nxt   = ch_grant;
    rvalid_nxt  = '0;
    done_nxt    = '0;
    rdata_nxt   = ch_rdata;
    err_nxt     = err;
    arvalid_nxt = axi_arvalid;
    araddr_nxt  = axi_araddr;
    arid_nxt    = axi_arid;
    unique case (state)
      S_IDLE: begin
        if (pick_vld) begin
          sel_nxt     = pick;
          grant_nxt   = 4'b0001 << pick;
          araddr_nxt  = ch_addr[32'(pick)*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
          arid_nxt    = {2'b00, pick};
          arvalid_nxt = 1'b1;
          state_nxt   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi_arready) begin
          arvalid_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          rdata_nxt       = axi_rdata;
          rvalid_nxt[sel] = 1'b1;
          if (cnt_inc <= BL_CNT) cnt_nxt = cnt_inc[CW-1:0];
          if (axi_rid != axi_arid) err_nxt = 1'b1;
          // Early or late rlast flags an error but the burst still closes on rlast.
          if (axi_rlast) begin
            if (cnt_inc != BL_CNT) err_nxt = 1'b1;
            done_nxt[sel] = 1'b1;
            state_nxt     = S_DONE;
          end else if (cnt_inc >= BL_CNT) begin
            err_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        grant_nxt = '0;
        ptr_nxt   = sel + 2'd1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      sel         <= '0;
      cnt         <= '0;
      ch_grant    <= '0;
      ch_rvalid   <= '0;
      ch_rdata    <= '0;
      ch_done     <= '0;
      err         <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arid    <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      ch_grant    <= grant_nxt;
      ch_rvalid   <= rvalid_nxt;
      ch_rdata    <= rdata_nxt;
      ch_done     <= done_nxt;
      err         <= err_nxt;
      axi_arvalid <= arvalid_nxt;
      axi_araddr  <= araddr_nxt;
      axi_arid    <= arid_nxt;
    end
  end

endmodule
